// File: rtl/fetch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_hazard_ctrl
//
// Pipeline sequencer for the IF stage and the IF/ID and ID/EX registers.
// Each cycle it decides:
//   - the PC update;
//   - whether IF/ID holds or flushes;
//   - whether a bubble goes into ID/EX.
// It arbitrates between these sources:
//   - EX branch redirects;
//   - load-use hazards;
//   - instruction-memory wait states;
//   - halt/resume requests.
// A run of imem wait states that lasts too long traps into a sticky ERROR
// state. Only reset leaves ERROR.
//
// Parameters:
//   IMEM_TIMEOUT  consecutive Imem_ready=0 cycles in RUN before ERROR (0 = off)
//   DRAIN_CYCLES  bubble cycles between halt_req and HALTED (>= 1)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   MemRead_EX   EX instruction is a load
//   RD_EX        EX destination register
//   RS1_ID       ID source register 1
//   RS2_ID       ID source register 2
//   Use_rs1_ID   ID instruction reads rs1
//   Use_rs2_ID   ID instruction reads rs2
//   PCSrc_EX     branch/jump taken, resolved in EX
//   Imem_ready   instruction memory data valid this cycle
//   halt_req     halt request (pulse or level)
//   resume       leave HALTED
//   PC_write     PC load enable
//   PCSrc        PC mux select (1 = branch target)
//   IF_ID_write  IF/ID register enable
//   IF_ID_flush  load NOP into IF/ID
//   ID_EX_flush  load bubble into ID/EX
//   halted       state is HALTED or ERROR
//   fetch_error  sticky imem timeout flag
//   state        RUN=0, DRAIN=1, HALTED=2, ERROR=3
//
// Optional feature (macro FETCH_HAZARD_PERF_EN) adds two saturating
// performance counters:
//   stall_count  RUN cycles stalled by a load-use hazard or an imem wait
//   flush_count  cycles with PCSrc=1
// ---------------------------------------------------------------------------
module fetch_hazard_ctrl #(
  parameter int IMEM_TIMEOUT = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_EX,
  input  logic [4:0]  RD_EX,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  input  logic        Use_rs1_ID,
  input  logic        Use_rs2_ID,
  input  logic        PCSrc_EX,
  input  logic        Imem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        PC_write,
  output logic        PCSrc,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        halted,
  output logic        fetch_error,
  output logic [1:0]  state
`ifdef FETCH_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  // The wait counter must be able to hold IMEM_TIMEOUT. Keep at least one
  // bit when the timeout is disabled, so the width is never zero.
  localparam int WaitW  = (IMEM_TIMEOUT > 0) ? $clog2(IMEM_TIMEOUT + 1) : 1;
  localparam int DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  localparam logic [WaitW-1:0]  WaitMax   = '1;
  localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              ferr_q, ferr_d;
  logic              load_use;
  logic              timeout_now;

  assign load_use = MemRead_EX && (RD_EX != 5'd0) &&
                    ((Use_rs1_ID && (RS1_ID == RD_EX)) ||
                     (Use_rs2_ID && (RS2_ID == RD_EX)));

  // Next-state logic and combinational control outputs.
  // In RUN, a branch redirect beats a load-use stall, and a load-use stall
  // beats an imem wait. A halt request still lets the current RUN cycle
  // behave normally. The halt request only redirects the next state, and a
  // simultaneous timeout wins over it.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    drain_d     = drain_q;
    ferr_d      = ferr_q;
    timeout_now = 1'b0;
    PC_write    = 1'b0;
    PCSrc       = 1'b0;
    IF_ID_write = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (PCSrc_EX) begin
          PC_write    = 1'b1;
          PCSrc       = 1'b1;
          IF_ID_write = 1'b1;
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          wait_d      = '0;
        end else if (load_use) begin
          // Freeze PC and IF/ID for this cycle and send a bubble into EX.
          // Next cycle the load has moved on, so the hazard clears by itself.
          ID_EX_flush = 1'b1;
        end else if (!Imem_ready) begin
          IF_ID_write = 1'b1;
          IF_ID_flush = 1'b1;
          wait_d      = (wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1);
          if ((IMEM_TIMEOUT != 0) && ((int'(wait_q) + 1) == IMEM_TIMEOUT)) begin
            timeout_now = 1'b1;
          end
        end else begin
          PC_write    = 1'b1;
          IF_ID_write = 1'b1;
          wait_d      = '0;
        end

        if (timeout_now) begin
          state_d = ST_ERROR;
          ferr_d  = 1'b1;
        end else if (halt_req) begin
          state_d = ST_DRAIN;
          drain_d = DrainInit;
        end
      end

      ST_DRAIN: begin
        ID_EX_flush = 1'b1;
        // Honour a late branch, so fetch restarts from the branch target
        // after resume.
        if (PCSrc_EX) begin
          PC_write    = 1'b1;
          PCSrc       = 1'b1;
          IF_ID_flush = 1'b1;
        end
        if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end

      ST_HALTED: begin
        ID_EX_flush = 1'b1;
        halted      = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end
      end

      default: begin
        ID_EX_flush = 1'b1;
        halted      = 1'b1;
      end
    endcase

    // While reset is asserted the pipeline is held with NOPs and bubbles,
    // whatever the inputs are doing.
    if (!reset) begin
      PC_write    = 1'b0;
      PCSrc       = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      halted      = 1'b0;
    end
  end

  // State, wait counter, drain counter and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      drain_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
      ferr_q  <= ferr_d;
    end
  end

  assign state       = state_q;
  assign fetch_error = ferr_q;

`ifdef FETCH_HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q;
  logic        stall_inc;

  // A RUN cycle stalls when it falls to the load-use or imem-wait branch,
  // which means no branch redirect is present.
  assign stall_inc = (state_q == ST_RUN) && !PCSrc_EX && (load_use || !Imem_ready);

  // Saturating counters. Only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (PCSrc && (flush_q != 32'hFFFF_FFFF)) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_hazard_ctrl
//
// Self-checking bench for fetch_hazard_ctrl.
// The DUT is built with IMEM_TIMEOUT=4 and DRAIN_CYCLES=3.
//
// The bench keeps a reference model of the sequencer. The model tracks:
//   - the current mode;
//   - the length of the current imem wait run;
//   - the number of drain cycles still to go.
// From these it predicts every control output.
//
// Each task drives one scenario. Each cycle it compares the packed DUT
// outputs against the model.
// ---------------------------------------------------------------------------
module tb_fetch_hazard_ctrl;

  localparam int TO = 4;
  localparam int DC = 3;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;
  localparam int M_ERR   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       MemRead_EX, Use_rs1_ID, Use_rs2_ID, PCSrc_EX, Imem_ready;
  logic       halt_req, resume;
  logic [4:0] RD_EX, RS1_ID, RS2_ID;
  logic       PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_flush;
  logic       halted, fetch_error;
  logic [1:0] state;
`ifdef FETCH_HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  // Packed output order:
  //   {PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_flush,
  //    halted, fetch_error, state[1:0]}
  logic [8:0] dutOut, expOut;
  assign dutOut = {PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_flush,
                   halted, fetch_error, state};

  int passCount = 0;
  int checkCount = 0;

  // Reference model state.
  int     mMode;
  int     mWaits;
  int     mDrainLeft;
  bit     mErr;
  longint mStalls;
  longint mFlushes;

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(.IMEM_TIMEOUT(TO), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .MemRead_EX(MemRead_EX), .RD_EX(RD_EX), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .Use_rs1_ID(Use_rs1_ID), .Use_rs2_ID(Use_rs2_ID), .PCSrc_EX(PCSrc_EX),
    .Imem_ready(Imem_ready), .halt_req(halt_req), .resume(resume),
    .PC_write(PC_write), .PCSrc(PCSrc), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .halted(halted),
    .fetch_error(fetch_error), .state(state)
`ifdef FETCH_HAZARD_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  // Model: return to the power-on condition. Reset clears the perf totals too.
  function automatic void modelReset();
    mMode = M_RUN;
    mWaits = 0;
    mDrainLeft = 0;
    mErr = 1'b0;
    mStalls = 0;
    mFlushes = 0;
  endfunction

  function automatic bit modelLoadUse();
    return MemRead_EX && (RD_EX != 0) &&
           ((Use_rs1_ID && RS1_ID == RD_EX) || (Use_rs2_ID && RS2_ID == RD_EX));
  endfunction

  // Model: outputs expected for the current inputs and model state.
  function automatic logic [8:0] modelOut();
    logic [4:0] ctl;
    logic       hlt;
    if (!reset) return {5'b00011, 1'b0, 1'b0, 2'd0};
    hlt = 1'b0;
    case (mMode)
      M_RUN: begin
        if (PCSrc_EX)          ctl = 5'b11111;
        else if (modelLoadUse()) ctl = 5'b00001;
        else if (!Imem_ready)  ctl = 5'b00110;
        else                   ctl = 5'b10100;
      end
      M_DRAIN: ctl = PCSrc_EX ? 5'b11011 : 5'b00001;
      default: begin
        ctl = 5'b00001;
        hlt = 1'b1;
      end
    endcase
    return {ctl, hlt, mErr, 2'(mMode)};
  endfunction

  // Model: advance one clock edge.
  function automatic void modelStep();
    logic [8:0] o;
    bit         toHit;
    if (!reset) begin
      modelReset();
      return;
    end
    o = modelOut();
    if (o[7]) mFlushes++;
    toHit = 1'b0;
    case (mMode)
      M_RUN: begin
        if (PCSrc_EX) begin
          mWaits = 0;
        end else if (modelLoadUse()) begin
          mStalls++;
        end else if (!Imem_ready) begin
          mStalls++;
          mWaits++;
          if (TO != 0 && mWaits == TO) toHit = 1'b1;
        end else begin
          mWaits = 0;
        end
        if (toHit) begin
          mMode = M_ERR;
          mErr = 1'b1;
        end else if (halt_req) begin
          mMode = M_DRAIN;
          mDrainLeft = DC;
        end
      end
      M_DRAIN: begin
        mDrainLeft--;
        if (mDrainLeft == 0) mMode = M_HALT;
      end
      M_HALT: begin
        if (resume) begin
          mMode = M_RUN;
          mWaits = 0;
        end
      end
      default: ;
    endcase
  endfunction

  // Inputs for a quiet RUN cycle: no hazards, memory ready.
  task automatic setIdle();
    MemRead_EX = 1'b0; RD_EX = 5'd0; RS1_ID = 5'd0; RS2_ID = 5'd0;
    Use_rs1_ID = 1'b0; Use_rs2_ID = 1'b0; PCSrc_EX = 1'b0;
    Imem_ready = 1'b1; halt_req = 1'b0; resume = 1'b0;
  endtask

  // Inputs are already set. Let them settle until the falling edge and
  // record the model's prediction in expOut.
  task automatic applyStimulus();
    if (!reset) modelReset();
    @(negedge clk);
    expOut = modelOut();
  endtask

  // Take the rising edge, advance the model, then move off the edge.
  task automatic endCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    // Hostile inputs while reset is held; outputs must stay forced.
    setIdle();
    PCSrc_EX = 1'b1; Imem_ready = 1'b0; halt_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL reset_hold c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
      endCycle();
    end
    reset = 1'b1;
    setIdle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL reset_release c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
      endCycle();
    end
  endtask

  task automatic test_load_use();
    // Case 0: rs2 hazard.
    // Case 1: rd=x0, so no hazard.
    // Case 2: rs1 hazard.
    // Case 3: register matches but is not used.
    // Case 4: no load.
    for (int i = 0; i < 5; i++) begin
      setIdle();
      MemRead_EX = (i != 4);
      RD_EX = (i == 1) ? 5'd0 : 5'd5;
      RS1_ID = (i == 2) ? 5'd5 : 5'd7;
      RS2_ID = (i == 2) ? 5'd9 : 5'd5;
      Use_rs1_ID = (i == 2);
      Use_rs2_ID = (i == 0 || i == 1 || i == 4);
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL load_use c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
      endCycle();
    end
  endtask

  task automatic test_branch_priority();
    // Case 0: branch together with load-use.
    // Case 1: branch together with an imem wait.
    // Case 2: branch alone.
    for (int i = 0; i < 3; i++) begin
      setIdle();
      PCSrc_EX = 1'b1;
      if (i == 0) begin
        MemRead_EX = 1'b1; RD_EX = 5'd3; RS1_ID = 5'd3; Use_rs1_ID = 1'b1;
      end
      if (i == 1) Imem_ready = 1'b0;
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL branch_prio c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
      endCycle();
    end
  endtask

  task automatic test_timeout();
    // Boundary: TO-1 misses, then ready. The wait run restarts and no error
    // follows.
    for (int i = 0; i < TO; i++) begin
      setIdle();
      Imem_ready = (i == TO - 1);
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL almost_timeout c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
      endCycle();
    end
    // TO misses in a row trap into ERROR. Then resume is pulsed, then the
    // memory comes back; neither may leave ERROR.
    for (int i = 0; i < TO + 3; i++) begin
      setIdle();
      Imem_ready = (i >= TO);
      resume = (i == TO);
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL timeout c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
      endCycle();
    end
    checkCount++;
    if (state !== 2'd3 || fetch_error !== 1'b1)
      $display("[TB] FAIL timeout_sticky: state %0d err %b, required state 3 err 1", state, fetch_error);
    else passCount++;
    // Reset clears the sticky error.
    reset = 1'b0;
    setIdle();
    applyStimulus();
    checkCount++;
    if (dutOut !== expOut) $display("[TB] FAIL timeout_reset: got %b expected %b", dutOut, expOut);
    else passCount++;
    endCycle();
    reset = 1'b1;
  endtask

  task automatic test_halt_drain();
    // Cycle 0: halt pulse.
    // Cycles 1..3: drain.
    // Cycles 4..5: halted.
    // Cycle 6: halt and resume together; resume wins.
    // Cycles 7..8: RUN again.
    for (int i = 0; i < 9; i++) begin
      setIdle();
      halt_req = (i == 0 || i == 2 || i == 6);
      resume = (i == 2 || i == 6);
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL halt_drain c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
      endCycle();
    end
  endtask

  task automatic test_drain_branch();
`ifdef FETCH_HAZARD_PERF_EN
    longint flushBefore;
`endif
    // Halt in the same cycle as a branch (cycle 0).
    // Then a branch on the first drain cycle (cycle 1).
    // Then resume once halted (cycle 5).
    for (int i = 0; i < 7; i++) begin
      setIdle();
      halt_req = (i == 0);
      PCSrc_EX = (i <= 1);
      resume = (i == 5);
`ifdef FETCH_HAZARD_PERF_EN
      if (i == 1) flushBefore = mFlushes;
`endif
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL drain_branch c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
      endCycle();
`ifdef FETCH_HAZARD_PERF_EN
      if (i == 1) begin
        @(negedge clk);
        checkCount++;
        if (flush_count !== 32'(flushBefore + 1))
          $display("[TB] FAIL drain_flush_count: got %0d required %0d", flush_count, flushBefore + 1);
        else passCount++;
        @(posedge clk);
        #1;
      end
`endif
    end
  endtask

  task automatic test_halt_timeout();
    // The halt arrives on the very cycle the timeout fires, so ERROR wins.
    for (int i = 0; i < TO + 2; i++) begin
      setIdle();
      Imem_ready = (i >= TO);
      halt_req = (i == TO - 1);
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL halt_vs_timeout c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
      endCycle();
    end
    reset = 1'b0;
    setIdle();
    applyStimulus();
    endCycle();
    reset = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 39) != 0);
      MemRead_EX = $urandom_range(0, 2) == 0;
      RD_EX = 5'($urandom_range(0, 3));
      RS1_ID = 5'($urandom_range(0, 3));
      RS2_ID = 5'($urandom_range(0, 3));
      Use_rs1_ID = 1'($urandom_range(0, 1));
      Use_rs2_ID = 1'($urandom_range(0, 1));
      PCSrc_EX = $urandom_range(0, 7) == 0;
      Imem_ready = $urandom_range(0, 9) > 2;
      halt_req = $urandom_range(0, 19) == 0;
      resume = $urandom_range(0, 3) == 0;
      applyStimulus();
      checkCount++;
      if (dutOut !== expOut) $display("[TB] FAIL random c%0d: got %b expected %b", i, dutOut, expOut);
      else passCount++;
`ifdef FETCH_HAZARD_PERF_EN
      checkCount++;
      if (stall_count !== 32'(mStalls) || flush_count !== 32'(mFlushes))
        $display("[TB] FAIL random_perf c%0d: got %0d/%0d required %0d/%0d",
                 i, stall_count, flush_count, mStalls, mFlushes);
      else passCount++;
`endif
      endCycle();
    end
    reset = 1'b1;
  endtask

  initial begin
    setIdle();
    modelReset();
    #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_timeout();
    test_halt_drain();
    test_drain_branch();
    test_halt_timeout();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Pipeline sequencer for the IF stage and the IF/ID and ID/EX registers.
- Each cycle it decides PC update (PC_write, PCSrc), IF/ID hold/flush and ID/EX bubble.
- Sources it arbitrates: branch redirect from EX, load-use hazards, instruction-memory wait states, and halt/resume requests.
- Holds a small FSM plus an imem-wait timeout counter that traps to a sticky error state.

Parameters:
IMEM_TIMEOUT, 16, consecutive Imem_ready=0 cycles in RUN before ERROR; 0 disables the timeout.
DRAIN_CYCLES, 3, bubble cycles inserted after halt_req before HALTED (≥1).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemRead_EX  input  1  instruction in EX is a load
RD_EX  input  5  destination register of the EX instruction
RS1_ID  input  5  rs1 of the ID instruction
RS2_ID  input  5  rs2 of the ID instruction
Use_rs1_ID  input  1  ID instruction reads rs1
Use_rs2_ID  input  1  ID instruction reads rs2
PCSrc_EX  input  1  branch/jump taken, resolved in EX
Imem_ready  input  1  instruction memory data valid this cycle
halt_req  input  1  halt request (single-cycle pulse or level)
resume  input  1  leave HALTED
PC_write  output  1  PC load enable to IF
PCSrc  output  1  PC mux select to IF (1 = PC_Branch)
IF_ID_write  output  1  IF/ID register enable
IF_ID_flush  output  1  load NOP into IF/ID
ID_EX_flush  output  1  load bubble into ID/EX
halted  output  1  state == HALTED or ERROR
fetch_error  output  1  sticky imem timeout flag
state  output  2  RUN=0, DRAIN=1, HALTED=2, ERROR=3

Behaviour:
- Reset (reset=0, async):
  - state=RUN, wait_cnt=0, drain_cnt=0, fetch_error=0.
  - While reset is held: PC_write=0, PCSrc=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, halted=0.
- Control outputs are combinational from state and inputs. State and counters are registered.
- load_use = MemRead_EX & (RD_EX≠0) & ((Use_rs1_ID & RS1_ID==RD_EX) | (Use_rs2_ID & RS2_ID==RD_EX)).
- RUN, per-cycle priority (first match wins):
  1. PCSrc_EX: PC_write=1, PCSrc=1, IF_ID_flush=1, ID_EX_flush=1, IF_ID_write=1. load_use is ignored. wait_cnt←0.
  2. load_use: PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0. Exactly one bubble per hazard occurrence. wait_cnt is unchanged.
  3. !Imem_ready: PC_write=0, IF_ID_write=1, IF_ID_flush=1. wait_cnt←wait_cnt+1. When IMEM_TIMEOUT≠0 and wait_cnt+1==IMEM_TIMEOUT: next state ERROR, fetch_error←1.
  4. Otherwise: PC_write=1, IF_ID_write=1, PCSrc=0, both flushes 0. wait_cnt←0.
- halt_req in RUN:
  - The current cycle still gets its normal RUN outputs, including a simultaneous branch redirect.
  - Next state DRAIN, drain_cnt←DRAIN_CYCLES-1.
  - A timeout in the same cycle takes precedence: go to ERROR.
- DRAIN:
  - PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0.
  - Exception: if PCSrc_EX=1, then PC_write=1, PCSrc=1, IF_ID_flush=1, so resume fetches from the branch target.
  - drain_cnt==0 → HALTED, else drain_cnt−1.
  - halt_req and resume are ignored.
- HALTED:
  - PC_write=0, IF_ID_write=0, ID_EX_flush=1, halted=1.
  - resume=1 → RUN next cycle, wait_cnt←0.
  - halt_req and resume both high → resume wins.
- ERROR:
  - Same outputs as HALTED, plus fetch_error=1.
  - Only reset exits this state; resume is ignored.
- wait_cnt is $clog2(IMEM_TIMEOUT+1) bits wide and saturates. It does not count outside RUN.

Optional Feature:
- Macro FETCH_HAZARD_PERF_EN.
- When defined, two extra outputs are added:
  - stall_count[31:0]: increments on every RUN cycle taking priority 2 or 3.
  - flush_count[31:0]: increments on every cycle with PCSrc=1.
- Both counters saturate at 0xFFFFFFFF and are cleared only by reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset release, Imem_ready=1, no hazards → cycle 1 after release: PC_write=1, IF_ID_write=1, all flushes 0, state=0.
2. MemRead_EX=1, RD_EX=5, RS2_ID=5, Use_rs2_ID=1 for one cycle → PC_write=0, IF_ID_write=0, ID_EX_flush=1 that cycle. With RD_EX=0 instead → no stall.
3. PCSrc_EX=1 together with a load_use condition → PC_write=1, PCSrc=1, IF_ID_flush=1, ID_EX_flush=1, no stall.
4. IMEM_TIMEOUT=4, Imem_ready=0 for 4 cycles:
   - cycles 1–3: IF_ID_flush=1, PC_write=0.
   - after cycle 4: state=3, fetch_error=1, halted=1.
   - resume pulse → still state 3. Reset → state 0, fetch_error=0.
5. halt_req pulse with DRAIN_CYCLES=3 → 3 cycles in state=1 with ID_EX_flush=1, then state=2, halted=1. resume → state 0 next cycle, PC_write=1.
6. halt_req with PCSrc_EX=1 on the first DRAIN cycle → PC_write=1, PCSrc=1 that cycle; drain count unaffected. With FETCH_HAZARD_PERF_EN: flush_count increments by 1.
